// File: rtl/cht_shift_seq_pkg.sv
// Shared encodings and defaults for the cht_shift_seq shift-register bank.
// Holds the command op codes, the FSM state type and the default lane widths.
package cht_shift_seq_pkg;

  localparam int WA_DEF = 16;
  localparam int WB_DEF = 16;
  localparam int WH_DEF = 5;
  localparam int CW_DEF = 4;

  localparam logic [1:0] OP_CLR  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_SHA  = 2'd2;
  localparam logic [1:0] OP_SHB  = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == OP_SHA) || (op == OP_SHB);
  endfunction

endpackage

// File: rtl/cht_shift_seq_lane.sv
// One shift lane: clear > load > shift priority, bidirectional single-step shift.
// sout is the bit that leaves the lane on the next shift in the current direction.
module cht_shift_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         dir,
  input  logic         sin,
  output logic [W-1:0] lane,
  output logic         sout
);

  logic [W-1:0] lane_q;
  logic [W-1:0] shifted;

  // dir=1 moves bits toward the MSB with sin entering at bit 0; dir=0 the reverse.
  always_comb begin
    if (dir) shifted = {lane_q[W-2:0], sin};
    else     shifted = {sin, lane_q[W-1:1]};
  end

  assign sout = dir ? lane_q[W-1] : lane_q[0];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (clear) begin
      lane_q <= '0;
    end else if (load) begin
      lane_q <= load_val;
    end else if (shift_en) begin
      lane_q <= shifted;
    end
  end

  assign lane = lane_q;

endmodule

// File: rtl/cht_shift_seq.sv
// Command-driven shift-register bank: two shift lanes, one hold lane, IDLE/RUN/DONE FSM.
// Build option CHT_SHIFT_SEQ_ROTATE_EN: lane A rotates on SHA instead of taking sin_a.
module cht_shift_seq
  import cht_shift_seq_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF,
  parameter int WH = WH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          kill,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic          cmd_dir,
  input  logic          sin_a,
  input  logic          sin_b,
  input  logic [WA-1:0] pdata_a,
  input  logic [WB-1:0] pdata_b,
  input  logic [WH-1:0] hsrc0,
  input  logic [WH-1:0] hsrc1,
  input  logic          hsel,
  output logic [WA-1:0] lane_a,
  output logic [WB-1:0] lane_b,
  output logic [WH-1:0] hold,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_b_q, sel_b_d;
  logic          dir_q, dir_d;

  logic          accept;
  logic          clr_lanes;
  logic          load_lanes;
  logic          shift_a;
  logic          shift_b;
  logic          sout_a;
  logic          sout_b;
  logic          sin_a_eff;
  logic [WH-1:0] hold_q;

  assign cmd_ready = (state_q == ST_IDLE) && !kill;
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_b_d = sel_b_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(cmd_op)) begin
            state_d = ST_RUN;
            cnt_d   = cmd_cnt;
            sel_b_d = (cmd_op == OP_SHB);
            dir_d   = cmd_dir;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // The shift at cnt==0 is the last one; the counter never wraps below zero.
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_b_q <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_b_q <= sel_b_d;
      dir_q   <= dir_d;
    end
  end

  // kill is already folded into accept, so it only needs to appear on the clear path.
  assign clr_lanes  = kill || (accept && (cmd_op == OP_CLR));
  assign load_lanes = accept && (cmd_op == OP_LOAD);
  assign shift_a    = (state_q == ST_RUN) && !sel_b_q;
  assign shift_b    = (state_q == ST_RUN) &&  sel_b_q;

`ifdef CHT_SHIFT_SEQ_ROTATE_EN
  logic unused_sigs;
  assign sin_a_eff   = sout_a;
  assign unused_sigs = sin_a ^ sout_b;
`else
  logic unused_sigs;
  assign sin_a_eff   = sin_a;
  assign unused_sigs = sout_a ^ sout_b;
`endif

  cht_shift_lane #(.W(WA)) u_lane_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clr_lanes),
    .load     (load_lanes),
    .load_val (pdata_a),
    .shift_en (shift_a),
    .dir      (dir_q),
    .sin      (sin_a_eff),
    .lane     (lane_a),
    .sout     (sout_a)
  );

  cht_shift_lane #(.W(WB)) u_lane_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clr_lanes),
    .load     (load_lanes),
    .load_val (pdata_b),
    .shift_en (shift_b),
    .dir      (dir_q),
    .sin      (sin_b),
    .lane     (lane_b),
    .sout     (sout_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (clr_lanes) begin
      hold_q <= '0;
    end else if (load_lanes) begin
      hold_q <= hsel ? hsrc1 : hsrc0;
    end
  end

  assign hold = hold_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_cht_shift_seq.sv
// Scoreboard bench for cht_shift_seq: commands push expected lanes and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_cht_shift_seq;
  import cht_shift_seq_pkg::*;

  localparam int WA = 16;
  localparam int WB = 16;
  localparam int WH = 5;
  localparam int CW = 4;

`ifdef CHT_SHIFT_SEQ_ROTATE_EN
  localparam logic [15:0] A_SHA_DN  = 16'h1800;
  localparam logic [15:0] A_SHA_UP  = 16'h6000;
  localparam logic [15:0] A_SHA_B2B = 16'h8246;
`else
  localparam logic [15:0] A_SHA_DN  = 16'hF800;
  localparam logic [15:0] A_SHA_UP  = 16'hE000;
  localparam logic [15:0] A_SHA_B2B = 16'h0246;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          kill = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = OP_CLR;
  logic [CW-1:0] cmd_cnt = '0;
  logic          cmd_dir = 1'b0;
  logic          sin_a = 1'b0;
  logic          sin_b = 1'b0;
  logic [WA-1:0] pdata_a = '0;
  logic [WB-1:0] pdata_b = '0;
  logic [WH-1:0] hsrc0 = '0;
  logic [WH-1:0] hsrc1 = '0;
  logic          hsel = 1'b0;
  logic [WA-1:0] lane_a;
  logic [WB-1:0] lane_b;
  logic [WH-1:0] hold;
  logic          busy;
  logic          done;

  cht_shift_seq #(.WA(WA), .WB(WB), .WH(WH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (kill),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_dir   (cmd_dir),
    .sin_a     (sin_a),
    .sin_b     (sin_b),
    .pdata_a   (pdata_a),
    .pdata_b   (pdata_b),
    .hsrc0     (hsrc0),
    .hsrc1     (hsrc1),
    .hsel      (hsel),
    .lane_a    (lane_a),
    .lane_b    (lane_b),
    .hold      (hold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WH-1:0] h;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // After edge Ek the negedge sees cyc==k; done must line up with the expected cycle.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("lane_a", 32'(lane_a), 32'(mon_e.a));
        check("lane_b", 32'(lane_b), 32'(mon_e.b));
        check("hold", 32'(hold), 32'(mon_e.h));
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  // Called at a negedge with the DUT idle; the command is accepted at the next edge.
  task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt, input logic dir,
                         input logic [WA-1:0] ea, input logic [WB-1:0] eb,
                         input logic [WH-1:0] eh);
    int   lat;
    exp_t e;
    lat = is_shift_op(op) ? int'(cnt) + 1 : 0;
    check("ready_idle", 32'(cmd_ready), 32'd1);
    e.a   = ea;
    e.b   = eb;
    e.h   = eh;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_dir   = dir;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      check("busy_active", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("busy_released", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_lane_a", 32'(lane_a), 32'd0);
    check("rst_lane_b", 32'(lane_b), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    pdata_a = 16'h8001; pdata_b = 16'h00F0; hsrc0 = 5'h0A; hsrc1 = 5'h15; hsel = 1'b1;
    run_cmd(OP_LOAD, 4'd0, 1'b0, 16'h8001, 16'h00F0, 5'h15);
    hsel = 1'b0;
    run_cmd(OP_LOAD, 4'd0, 1'b0, 16'h8001, 16'h00F0, 5'h0A);

    sin_a = 1'b1;
    run_cmd(OP_SHA, 4'd3, 1'b0, A_SHA_DN, 16'h00F0, 5'h0A);
    sin_b = 1'b1;
    run_cmd(OP_SHB, 4'd0, 1'b1, A_SHA_DN, 16'h01E1, 5'h0A);
    sin_a = 1'b0;
    run_cmd(OP_SHA, 4'd1, 1'b1, A_SHA_UP, 16'h01E1, 5'h0A);

    // SHB cnt=7 killed during its second RUN cycle: no done, everything zero.
    sin_b = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_SHB; cmd_cnt = 4'd7; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("lane_b_before_kill", 32'(lane_b), 32'h00F0);
    kill = 1'b1;
    #1;
    check("ready_killed_run", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("kill_lane_a", 32'(lane_a), 32'd0);
    check("kill_lane_b", 32'(lane_b), 32'd0);
    check("kill_hold", 32'(hold), 32'd0);
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_ready_low", 32'(cmd_ready), 32'd0);
    kill = 1'b0;
    #1;
    check("ready_after_kill", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);

    pdata_a = 16'h1234; pdata_b = 16'hABCD; hsrc1 = 5'h1F; hsel = 1'b1;
    run_cmd(OP_LOAD, 4'd0, 1'b0, 16'h1234, 16'hABCD, 5'h1F);

    // SHA cnt=2 then CLR held valid throughout: CLR accepted at E5, done at E5.
    sin_a = 1'b0;
    mon_e.a = A_SHA_B2B; mon_e.b = 16'hABCD; mon_e.h = 5'h1F; mon_e.cyc = cyc + 4;
    sb.push_back(mon_e);
    mon_e.a = '0; mon_e.b = '0; mon_e.h = '0; mon_e.cyc = cyc + 6;
    sb.push_back(mon_e);
    cmd_valid = 1'b1; cmd_op = OP_SHA; cmd_cnt = 4'd2; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_op = OP_CLR;
    repeat (3) @(negedge clk);
    check("b2b_ready_in_done", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_busy_clr_done", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);

    pdata_a = 16'h5A5A; pdata_b = 16'hA5A5; hsrc0 = 5'h0C; hsel = 1'b0;
    run_cmd(OP_LOAD, 4'd0, 1'b0, 16'h5A5A, 16'hA5A5, 5'h0C);

    // Asynchronous reset in the middle of RUN: immediate abort, no done afterwards.
    sin_a = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_SHA; cmd_cnt = 4'd7; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lane_a", 32'(lane_a), 32'd0);
    check("arst_lane_b", 32'(lane_b), 32'd0);
    check("arst_hold", 32'(hold), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cht_shift_seq.md
# cht_shift_seq

Sequential shift-register bank with a command-driven control FSM. It holds the lane state that the combinational shift/select next-state network produces and consumes. Two shift lanes and one hold lane are registered here. A small valid/ready command port schedules clear, parallel load and multi-step shift operations, so the downstream network always sees stable registered lanes.

## Interface
- WA, 16: lane A width (bits)
- WB, 16: lane B width (bits)
- WH, 5: hold lane width (bits)
- CW, 4: shift-count width; one command shifts 1..2^CW times
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- kill  in  1  synchronous clear, highest priority
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready at a rising edge
- cmd_op  in  2  0=CLR, 1=LOAD, 2=SHA, 3=SHB
- cmd_cnt  in  CW  shift count minus one
- cmd_dir  in  1  0=shift down (bit n←n+1, MSB←serial in), 1=shift up (bit n←n-1, LSB←serial in)
- sin_a, sin_b  in  1  serial inputs, lanes A/B
- pdata_a  in  WA  parallel load value, lane A
- pdata_b  in  WB  parallel load value, lane B
- hsrc0, hsrc1  in  WH  hold-lane load sources
- hsel  in  1  1 selects hsrc1, 0 selects hsrc0
- lane_a  out  WA  registered lane A
- lane_b  out  WB  registered lane B
- hold  out  WH  registered hold lane
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DONE. cmd_ready = (state==IDLE) && !kill.
- CLR accepted: all lanes become 0 at the accepting edge; next state is DONE.
- LOAD accepted: at the accepting edge, lane_a←pdata_a, lane_b←pdata_b, hold←(hsel?hsrc1:hsrc0); next state is DONE.
- SHA/SHB accepted: latch op, dir and counter←cmd_cnt; next state is RUN. No shift happens at the accepting edge.
- RUN: each edge performs one shift of the selected lane using the latched dir and the live sin_x. The counter then decrements. When the counter is 0 at the edge, the shift still occurs and the FSM moves to DONE. The unselected lanes hold their values.
- DONE: done=1 for exactly one cycle, then IDLE.
- kill: at the edge, zero all lanes, go to IDLE, and clear the counter. done is not asserted. kill overrides an accepting command and RUN shifts.
- Commands held while busy are not consumed. Nothing is queued.
- Counter width is CW. Zero-extend for arithmetic and never wrap below 0.

## Timing
- Reset values: lane_a=0, lane_b=0, hold=0, busy=0, done=0, state IDLE. cmd_ready=1 in the first cycle after reset release unless kill is high.
- Reset asserted mid-RUN aborts immediately with no done pulse.
- CLR/LOAD: lanes update at accept edge E0; done is high during cycle E0..E1; cmd_ready returns after E1.
- SHA/SHB with cmd_cnt=n: shifts at E1..E(n+1); done is high during E(n+1)..E(n+2); total occupancy is n+3 cycles including the accept cycle.
- done and busy decode from registered state only, with no combinational path from inputs. cmd_ready depends combinationally on kill only.

## Configuration
- CHT_SHIFT_SEQ_ROTATE_EN defined: the serial-in bit for SHA is replaced by the bit shifted out of lane A, so lane A rotates. SHB is unaffected. sin_a remains a port and is ignored.
- Not defined: SHA shifts in sin_a as specified above.

## Structure
- Package cht_shift_seq_pkg holds:
  - op encoding constants OP_CLR/OP_LOAD/OP_SHA/OP_SHB;
  - FSM state typedef;
  - default widths.
- Sub-module cht_shift_lane: parameterised width. Inputs are clear, load, load value, shift enable, dir and serial in; outputs are the lane value and the shifted-out bit. Instantiated for lane A and lane B.
- The hold lane and the FSM live in the top module.

## Test plan
- Reset then LOAD with pdata_a=16'h8001, pdata_b=16'h00F0, hsel=1, hsrc1=5'h15 -> lane_a=8001, lane_b=00F0, hold=15 after E0; done high one cycle at E0..E1.
- SHA with cmd_cnt=3, cmd_dir=0, sin_a=1, starting from lane_a=8001 -> after 4 shifts lane_a=F800; done high at E4..E5; busy high from E0 to E5.
- Same SHA with CHT_SHIFT_SEQ_ROTATE_EN defined, starting from lane_a=8001 -> lane_a=1800.
- SHB with cmd_cnt=0, cmd_dir=1, sin_b=1, starting from lane_b=00F0 -> lane_b=01E1 after a single shift.
- kill asserted in the second RUN cycle of SHB with cnt=7 -> all lanes 0 next edge, state IDLE, done never pulses, cmd_ready=1 once kill drops.
- cmd_valid held high during RUN with a second CLR -> the CLR is accepted only in the IDLE cycle after done; back-to-back occupancy shows no lost or duplicated command.
